// File: rtl/mem_access_unit_if.sv
// Request / bus / response bundle for mem_access_unit.
// The slave modport is the unit itself; the master modport is the pipeline
// and memory side that drives requests and acknowledges bus cycles.
interface mem_access_unit_if;
  // M-stage request
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  // Data-memory bus
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  // Completion towards W stage
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_exc;
  logic        stall;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output rsp_valid, rsp_data, rsp_exc, stall
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  rsp_valid, rsp_data, rsp_exc, stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one load/store from the M stage, checks
// alignment and data-memory range, runs a single bus cycle with a bounded
// wait for bus_ack, and returns a one-cycle response with right-aligned
// (zero-filled) load data or an address exception code.
module mem_access_unit #(
  parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  mif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------
  function automatic logic is_store(input logic [2:0] op);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [4:0] exc_code(input logic [2:0] op);
    exc_code = is_store(op) ? EXC_ADES : EXC_ADEL;
  endfunction

  // Misalignment for the access size, or an address past data memory.
  function automatic logic addr_fault(input logic [2:0] op, input logic [31:0] addr);
    logic misaligned;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
    addr_fault = misaligned || (addr >= DM_LIMIT);
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_SH:   byte_enable = lo[1] ? 4'b1100 : 4'b0011;
      OP_SB:   byte_enable = 4'b0001 << lo;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  // Stores replicate the datum across every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      OP_SW:   lane_wdata = wdata;
      OP_SH:   lane_wdata = {2{wdata[15:0]}};
      OP_SB:   lane_wdata = {4{wdata[7:0]}};
      default: lane_wdata = 32'h0000_0000;
    endcase
  endfunction

  // Loads are shifted down to bit 0 and zero-filled; sign extension is W-stage work.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [31:0] half_s;
    logic [31:0] byte_s;
    half_s = rdata >> {lo[1], 4'b0000};
    byte_s = rdata >> {lo, 3'b000};
    case (op)
      OP_LW:         load_extract = rdata;
      OP_LH, OP_LHU: load_extract = {16'h0000, half_s[15:0]};
      OP_LB, OP_LBU: load_extract = {24'h00_0000, byte_s[7:0]};
      default:       load_extract = 32'h0000_0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t           state_r,     state_nxt_s;
  logic [CNT_W-1:0] count_r,     count_nxt_s;
  logic [2:0]       op_r,        op_nxt_s;
  logic [1:0]       lo_r,        lo_nxt_s;
  logic             req_ready_r, req_ready_nxt_s;
  logic             bus_req_r,   bus_req_nxt_s;
  logic             bus_we_r,    bus_we_nxt_s;
  logic [31:0]      bus_addr_r,  bus_addr_nxt_s;
  logic [3:0]       bus_be_r,    bus_be_nxt_s;
  logic [31:0]      bus_wdata_r, bus_wdata_nxt_s;
  logic             rsp_valid_r, rsp_valid_nxt_s;
  logic [31:0]      rsp_data_r,  rsp_data_nxt_s;
  logic [4:0]       rsp_exc_r,   rsp_exc_nxt_s;

  logic             accept_s;
  logic             ack_s;

  assign accept_s = mif.req_valid && req_ready_r;
  assign ack_s    = mif.bus_ack && bus_req_r;

  // Next-state and next-output decode for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    count_nxt_s     = count_r;
    op_nxt_s        = op_r;
    lo_nxt_s        = lo_r;
    req_ready_nxt_s = 1'b0;
    bus_req_nxt_s   = bus_req_r;
    bus_we_nxt_s    = bus_we_r;
    bus_addr_nxt_s  = bus_addr_r;
    bus_be_nxt_s    = bus_be_r;
    bus_wdata_nxt_s = bus_wdata_r;
    rsp_valid_nxt_s = 1'b0;
    rsp_data_nxt_s  = 32'h0000_0000;
    rsp_exc_nxt_s   = EXC_NONE;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_nxt_s    = mif.req_op;
          lo_nxt_s    = mif.req_addr[1:0];
          count_nxt_s = '0;
          if (addr_fault(mif.req_op, mif.req_addr)) begin
            // Faulting requests never touch the bus.
            state_nxt_s     = ST_RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_exc_nxt_s   = exc_code(mif.req_op);
          end else begin
            state_nxt_s     = ST_ACCESS;
            bus_req_nxt_s   = 1'b1;
            bus_we_nxt_s    = is_store(mif.req_op);
            bus_addr_nxt_s  = {mif.req_addr[31:2], 2'b00};
            bus_be_nxt_s    = byte_enable(mif.req_op, mif.req_addr[1:0]);
            bus_wdata_nxt_s = lane_wdata(mif.req_op, mif.req_wdata);
          end
        end else begin
          req_ready_nxt_s = 1'b1;
        end
      end

      ST_ACCESS: begin
        if (ack_s) begin
          // An ack on the final counted cycle still completes normally.
          state_nxt_s     = ST_RESP;
          bus_req_nxt_s   = 1'b0;
          bus_we_nxt_s    = 1'b0;
          bus_addr_nxt_s  = 32'h0000_0000;
          bus_be_nxt_s    = 4'b0000;
          bus_wdata_nxt_s = 32'h0000_0000;
          rsp_valid_nxt_s = 1'b1;
          rsp_data_nxt_s  = is_store(op_r) ? 32'h0000_0000
                                           : load_extract(op_r, lo_r, mif.bus_rdata);
        end else if (count_r == CNT_LAST) begin
          state_nxt_s     = ST_RESP;
          bus_req_nxt_s   = 1'b0;
          bus_we_nxt_s    = 1'b0;
          bus_addr_nxt_s  = 32'h0000_0000;
          bus_be_nxt_s    = 4'b0000;
          bus_wdata_nxt_s = 32'h0000_0000;
          rsp_valid_nxt_s = 1'b1;
          rsp_exc_nxt_s   = exc_code(op_r);
        end else begin
          count_nxt_s = count_r + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_nxt_s     = ST_IDLE;
        count_nxt_s     = '0;
        req_ready_nxt_s = 1'b1;
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        count_nxt_s     = '0;
        bus_req_nxt_s   = 1'b0;
        bus_we_nxt_s    = 1'b0;
        bus_addr_nxt_s  = 32'h0000_0000;
        bus_be_nxt_s    = 4'b0000;
        bus_wdata_nxt_s = 32'h0000_0000;
      end
    endcase
  end

  // State register and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      op_r        <= 3'b000;
      lo_r        <= 2'b00;
      req_ready_r <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      rsp_exc_r   <= 5'd0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      op_r        <= op_nxt_s;
      lo_r        <= lo_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      bus_req_r   <= bus_req_nxt_s;
      bus_we_r    <= bus_we_nxt_s;
      bus_addr_r  <= bus_addr_nxt_s;
      bus_be_r    <= bus_be_nxt_s;
      bus_wdata_r <= bus_wdata_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_exc_r   <= rsp_exc_nxt_s;
    end
  end

  assign mif.req_ready = req_ready_r;
  assign mif.bus_req   = bus_req_r;
  assign mif.bus_we    = bus_we_r;
  assign mif.bus_addr  = bus_addr_r;
  assign mif.bus_be    = bus_be_r;
  assign mif.bus_wdata = bus_wdata_r;
  assign mif.rsp_valid = rsp_valid_r;
  assign mif.rsp_data  = rsp_data_r;
  assign mif.rsp_exc   = rsp_exc_r;
  // The pipeline is held for as long as a request is in flight.
  assign mif.stall     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected responses are queued when a
// request is driven and popped when the unit raises rsp_valid.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_access_unit_if mif();

  mem_access_unit #(
    .DM_LIMIT (32'h0000_3000),
    .TIMEOUT  (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  exc;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction; called and returns on a negedge.
  task automatic txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int ack_cycle, input bit hold_valid, input int exp_bus_cycles,
                     input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                     input logic exp_we, input logic [31:0] exp_bwdata,
                     input logic [31:0] exp_data, input logic [4:0] exp_exc);
    rsp_t exp_r;
    rsp_t got_r;
    int   bus_cycles;
    int   lat;
    bit   seen;
    bit   stable;
    exp_r.data = exp_data;
    exp_r.exc  = exp_exc;
    check({tag, ":ready_before"}, {31'd0, mif.req_ready}, 32'd1);
    mif.req_valid = 1'b1;
    mif.req_op    = op;
    mif.req_addr  = addr;
    mif.req_wdata = wdata;
    exp_q.push_back(exp_r);
    @(negedge clk);
    if (!hold_valid) mif.req_valid = 1'b0;
    bus_cycles = 0;
    lat        = 0;
    seen       = 1'b0;
    stable     = 1'b1;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (mif.rsp_valid === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        got_r = exp_q.pop_front();
        check({tag, ":rsp_data"},  mif.rsp_data, got_r.data);
        check({tag, ":rsp_exc"},   {27'd0, mif.rsp_exc}, {27'd0, got_r.exc});
        check({tag, ":resp_busy"}, {29'd0, mif.stall, mif.req_ready, mif.bus_req}, 32'd4);
        mif.req_valid = 1'b0;
      end else begin
        if (mif.bus_req === 1'b1) begin
          bus_cycles++;
          if (bus_cycles == 1) begin
            check({tag, ":bus_addr"},  mif.bus_addr, exp_baddr);
            check({tag, ":bus_be"},    {28'd0, mif.bus_be}, {28'd0, exp_be});
            check({tag, ":bus_we"},    {31'd0, mif.bus_we}, {31'd0, exp_we});
            check({tag, ":bus_wdata"}, mif.bus_wdata, exp_bwdata);
          end else begin
            stable &= (mif.bus_addr === exp_baddr) && (mif.bus_be === exp_be) &&
                      (mif.bus_we === exp_we) && (mif.bus_wdata === exp_bwdata);
          end
        end
        stable &= (mif.stall === 1'b1) && (mif.req_ready === 1'b0);
        mif.bus_ack   = (mif.bus_req === 1'b1) && (bus_cycles == ack_cycle);
        mif.bus_rdata = rdata;
        @(negedge clk);
      end
    end
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'h0000_0000;
    check({tag, ":rsp_seen"},   {31'd0, seen}, 32'd1);
    check({tag, ":bus_cycles"}, bus_cycles, exp_bus_cycles);
    check({tag, ":latency"},    lat, exp_bus_cycles + 1);
    check({tag, ":stable"},     {31'd0, stable}, 32'd1);
    @(negedge clk);
    check({tag, ":pulse_end"}, {mif.rsp_data[30:0], mif.rsp_valid}, 32'd0);
    check({tag, ":exc_clear"}, {27'd0, mif.rsp_exc}, 32'd0);
    check({tag, ":idle"},      {30'd0, mif.stall, mif.req_ready}, 32'd1);
  endtask

  initial begin
    reset         = 1'b0;
    mif.req_valid = 1'b0;
    mif.req_op    = 3'b000;
    mif.req_addr  = 32'h0000_0000;
    mif.req_wdata = 32'h0000_0000;
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'h0000_0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:req_ready", {31'd0, mif.req_ready}, 32'd0);
    check("rst:bus_req",   {31'd0, mif.bus_req},   32'd0);
    check("rst:rsp_valid", {31'd0, mif.rsp_valid}, 32'd0);
    check("rst:stall",     {31'd0, mif.stall},     32'd0);
    check("rst:bus_addr",  mif.bus_addr,           32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel:req_ready", {31'd0, mif.req_ready}, 32'd1);

    // Stray ack in IDLE is ignored
    mif.bus_ack = 1'b1;
    @(negedge clk);
    mif.bus_ack = 1'b0;
    check("idle_ack:rsp_valid", {31'd0, mif.rsp_valid}, 32'd0);
    check("idle_ack:stall",     {31'd0, mif.stall},     32'd0);

    //      tag         op     addr           wdata          rdata          ack hv bus addr           be      we    bwdata         data           exc
    txn("lb_006",  3'd3, 32'h0000_0006, 32'h0000_0000, 32'hAABB_CCDD,  2, 0,  2, 32'h0000_0004, 4'hF, 1'b0, 32'h0000_0000, 32'h0000_00BB, 5'd0);
    txn("sh_102",  3'd6, 32'h0000_0102, 32'h1234_ABCD, 32'hFFFF_FFFF,  1, 0,  1, 32'h0000_0100, 4'hC, 1'b1, 32'hABCD_ABCD, 32'h0000_0000, 5'd0);
    txn("lw_mis",  3'd0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000,  0, 0,  0, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd4);
    txn("sw_lim",  3'd5, 32'h0000_3000, 32'h1111_2222, 32'h0000_0000,  0, 0,  0, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd5);
    txn("sb_2fff", 3'd7, 32'h0000_2FFF, 32'h0000_005A, 32'h0000_0000,  3, 0,  3, 32'h0000_2FFC, 4'h8, 1'b1, 32'h5A5A_5A5A, 32'h0000_0000, 5'd0);
    txn("lw_tmo",  3'd0, 32'h0000_0010, 32'h0000_0000, 32'h1357_9BDF,  0, 0, 15, 32'h0000_0010, 4'hF, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd4);
    txn("lw_ack15",3'd0, 32'h0000_0010, 32'h0000_0000, 32'h1357_9BDF, 15, 0, 15, 32'h0000_0010, 4'hF, 1'b0, 32'h0000_0000, 32'h1357_9BDF, 5'd0);
    txn("lh_022",  3'd1, 32'h0000_0022, 32'h0000_0000, 32'h8765_4321,  1, 1,  1, 32'h0000_0020, 4'hF, 1'b0, 32'h0000_0000, 32'h0000_8765, 5'd0);
    txn("lhu_020", 3'd2, 32'h0000_0020, 32'h0000_0000, 32'h8765_4321,  4, 0,  4, 32'h0000_0020, 4'hF, 1'b0, 32'h0000_0000, 32'h0000_4321, 5'd0);
    txn("lbu_001", 3'd4, 32'h0000_0001, 32'h0000_0000, 32'h8765_4321,  1, 0,  1, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000, 32'h0000_0043, 5'd0);
    txn("lb_003",  3'd3, 32'h0000_0003, 32'h0000_0000, 32'h1122_3344,  1, 0,  1, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000, 32'h0000_0011, 5'd0);
    txn("sw_040",  3'd5, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000,  2, 0,  2, 32'h0000_0040, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 5'd0);
    txn("sh_000",  3'd6, 32'h0000_0000, 32'h0000_BEEF, 32'h0000_0000,  1, 0,  1, 32'h0000_0000, 4'h3, 1'b1, 32'hBEEF_BEEF, 32'h0000_0000, 5'd0);
    txn("lh_mis",  3'd1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,  0, 0,  0, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd4);
    txn("sh_mis",  3'd6, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000,  0, 0,  0, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd5);
    txn("lw_lim",  3'd0, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000,  0, 0,  0, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd4);
    txn("lw_2ffc", 3'd0, 32'h0000_2FFC, 32'h0000_0000, 32'hCAFE_F00D,  1, 0,  1, 32'h0000_2FFC, 4'hF, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 5'd0);
    txn("sw_tmo",  3'd5, 32'h0000_0044, 32'h0BAD_F00D, 32'h0000_0000,  0, 0, 15, 32'h0000_0044, 4'hF, 1'b1, 32'h0BAD_F00D, 32'h0000_0000, 5'd5);

    // Reset in the middle of an ACCESS aborts silently
    mif.req_valid = 1'b1;
    mif.req_op    = 3'd0;
    mif.req_addr  = 32'h0000_0050;
    @(negedge clk);
    mif.req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst:bus_req_before", {31'd0, mif.bus_req}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst:bus_req",   {31'd0, mif.bus_req},   32'd0);
    check("mid_rst:rsp_valid", {31'd0, mif.rsp_valid}, 32'd0);
    check("mid_rst:req_ready", {31'd0, mif.req_ready}, 32'd0);
    check("mid_rst:stall",     {31'd0, mif.stall},     32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst:ready_after", {31'd0, mif.req_ready}, 32'd1);
    check("mid_rst:no_rsp",      {31'd0, mif.rsp_valid}, 32'd0);
    @(negedge clk);
    check("mid_rst:no_rsp_late", {30'd0, mif.rsp_valid, mif.bus_req}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
